data_mem_responder: RTL and testbench

//   Target-side data memory for the MEM stage: accepts one load/store request at a time and

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/load_store_align.sv | 59 +++++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//   - funct3 access-size encodings (RV32I load/store)
//   - FSM state enum
//   - word / byte-enable widths
//   - helper to spot the zero-extending load encodings
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = WORD_W / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // BU/HU only exist as loads; a store carrying them is illegal.
  function automatic logic is_unsigned_sz(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for RV32I loads and stores.
// Ports:
//   i_funct3   access size (B/H/W/BU/HU)
//   i_offset   byte offset within the word (address[1:0])
//   i_st_data  LSB-aligned store data
//   i_raw_word word currently held in the array
//   o_be       byte enables for the store
//   o_st_word  store data replicated into the addressed lane(s)
//   o_ld_word  sign/zero-extended load result
//   o_size_err misaligned H/W access or unknown size encoding
module load_store_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_offset,
  input  logic [WORD_W-1:0] i_st_data,
  input  logic [WORD_W-1:0] i_raw_word,
  output logic [BE_W-1:0]   o_be,
  output logic [WORD_W-1:0] o_st_word,
  output logic [WORD_W-1:0] o_ld_word,
  output logic              o_size_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_raw_word[8*i_offset +: 8];
  assign w_half = i_offset[1] ? i_raw_word[31:16] : i_raw_word[15:0];

  always_comb begin
    o_be       = '0;
    o_st_word  = '0;
    o_ld_word  = '0;
    o_size_err = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be      = BE_W'(1) << i_offset;
        o_st_word = {4{i_st_data[7:0]}};
        o_ld_word = (i_funct3 == F3_BU) ? {24'd0, w_byte}
                                        : {{24{w_byte[7]}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_size_err = i_offset[0];
        o_be       = i_offset[1] ? 4'b1100 : 4'b0011;
        o_st_word  = {2{i_st_data[15:0]}};
        o_ld_word  = (i_funct3 == F3_HU) ? {16'd0, w_half}
                                         : {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        o_size_err = (i_offset != 2'b00);
        o_be       = '1;
        o_st_word  = i_st_data;
        o_ld_word  = i_raw_word;
      end
      default: o_size_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Target-side data memory for the MEM stage. Accepts one load/store at a
// time, completes it LATENCY cycles after acceptance with a one-cycle
// resp_valid pulse. Requests arriving while busy are dropped.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   mem_read     load request
//   mem_write    store request (wins over mem_read)
//   address      byte address
//   write_data   LSB-aligned store data
//   funct3       access size
//   busy         request in flight
//   resp_valid   completion pulse
//   read_data    extended load result (held between loads)
//   err          access not performed (qualified by resp_valid)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] write_data,
  input  logic [2:0]        funct3,
  output logic              busy,
  output logic              resp_valid,
  output logic [WORD_W-1:0] read_data,
  output logic              err
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy, r_resp_valid, r_err;
  logic [WORD_W-1:0]  r_read_data;

  // Latched request
  logic               r_is_write;
  logic [31:0]        r_addr;
  logic [WORD_W-1:0]  r_wdata;
  logic [2:0]         r_funct3;

  logic [WORD_W-1:0]  r_mem [DEPTH_WORDS];

  logic               w_accept, w_enter_resp, w_do_write;
  logic [AW-1:0]      w_idx;
  logic               w_oor, w_sz_err, w_err;
  logic [BE_W-1:0]    w_be;
  logic [WORD_W-1:0]  w_st_word, w_ld_word;

  assign w_accept     = (r_state == ST_IDLE) && (mem_read || mem_write);
  assign w_enter_resp = (r_state == ST_WAIT) && (r_cnt == CNT_LAST);
  assign w_idx        = r_addr[2 +: AW];
  assign w_oor        = |r_addr[31:AW+2];
  assign w_err        = w_sz_err || w_oor || (r_is_write && is_unsigned_sz(r_funct3));
  // Gate with rst_n so a reset landing on the completion edge still
  // abandons the store.
  assign w_do_write   = w_enter_resp && r_is_write && !w_err && rst_n;

  load_store_align u_align (
    .i_funct3   (r_funct3),
    .i_offset   (r_addr[1:0]),
    .i_st_data  (r_wdata),
    .i_raw_word (r_mem[w_idx]),
    .o_be       (w_be),
    .o_st_word  (w_st_word),
    .o_ld_word  (w_ld_word),
    .o_size_err (w_sz_err)
  );

  // The WAIT state absorbs all LATENCY cycles between acceptance and the
  // completion edge, so the counter runs 0..LATENCY-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: if (mem_read || mem_write) begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (r_cnt == CNT_LAST) w_state_nxt = ST_RESP;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_read_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_resp_valid <= w_enter_resp;
      if (w_accept)                r_busy <= 1'b1;
      else if (r_state == ST_RESP) r_busy <= 1'b0;
      if (w_enter_resp) begin
        r_err <= w_err;
        // Load result comes from the pre-store array; stores leave it alone.
        if (!r_is_write) r_read_data <= w_err ? '0 : w_ld_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_write <= mem_write;
      r_addr     <= address;
      r_wdata    <= write_data;
      r_funct3   <= funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_word[8*b +: 8];
      end
    end
  end

  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign read_data  = r_read_data;
  assign err        = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int NVEC  = 24;

  logic        clk;
  logic        rst_n, mem_read, mem_write;
  logic [31:0] address, write_data;
  logic [2:0]  funct3;
  logic        busy, resp_valid, err;
  logic [31:0] read_data;

  logic        rst1_n, rd1, wr1;
  logic [31:0] addr1, wd1;
  logic [2:0]  f31;
  logic        busy1, resp1, err1;
  logic [31:0] rdata1;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .funct3(funct3),
    .busy(busy), .resp_valid(resp_valid), .read_data(read_data), .err(err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .mem_read(rd1), .mem_write(wr1),
    .address(addr1), .write_data(wd1), .funct3(f31),
    .busy(busy1), .resp_valid(resp1), .read_data(rdata1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] erd;
    logic        eerr;
    logic        ghost;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_rd = 32'h0;

  // Scoreboard side: every response must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_err", {31'd0, err}, {31'd0, e.err});
        chk("resp_read_data", read_data, e.rd);
      end
    end
  end

  task automatic clear_req();
    mem_read = 1'b0; mem_write = 1'b0;
    address = '0; write_data = '0; funct3 = '0;
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk); #1;
    mem_write  = v.wr;
    mem_read   = !v.wr;
    address    = v.a;
    write_data = v.wd;
    funct3     = v.f3;
    e.err = v.eerr;
    e.cyc = cyc + 1 + LAT;
    if (!v.wr) last_rd = v.eerr ? 32'h0 : v.erd;
    e.rd = last_rd;
    exp_q.push_back(e);
    @(negedge clk); #1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (v.ghost) begin
      // Second request while busy: must be dropped.
      mem_write = 1'b0; mem_read = 1'b1; address = 32'h10; funct3 = 3'b010;
      @(negedge clk); #1;
    end
    clear_req();
    for (int i = 0; i < 20; i++) begin
      if (!busy && !resp_valid && exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("drain_outstanding", exp_q.size(), 32'd0);
    chk("busy_released", {31'd0, busy}, 32'd0);
  endtask

  task automatic l1_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] erd, input logic eerr,
                        input logic kill);
    @(negedge clk); #1;
    wr1 = wr; rd1 = !wr; addr1 = a; wd1 = wd; f31 = f3;
    @(negedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b0;
    chk("l1_busy", {31'd0, busy1}, 32'd1);
    chk("l1_no_early_resp", {31'd0, resp1}, 32'd0);
    if (kill) rst1_n = 1'b0;
    @(negedge clk); #1;
    rst1_n = 1'b1;
    if (kill) begin
      chk("l1_killed_no_resp", {31'd0, resp1}, 32'd0);
      chk("l1_killed_busy", {31'd0, busy1}, 32'd0);
    end else begin
      chk("l1_resp", {31'd0, resp1}, 32'd1);
      chk("l1_err", {31'd0, err1}, {31'd0, eerr});
      if (!wr) chk("l1_read_data", rdata1, erd);
    end
    @(negedge clk); #1;
    chk("l1_idle", {31'd0, busy1 | resp1}, 32'd0);
  endtask

  vec_t tbl [NVEC];

  initial begin
    //          wr    addr        wdata         f3      exp rd        err   ghost
    tbl = '{
      '{1'b1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 1'b0},
      '{1'b0, 32'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 1'b0},
      '{1'b0, 32'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0, 1'b0},
      '{1'b0, 32'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 1'b0},
      '{1'b0, 32'h012, 32'h0,        3'b101, 32'h0000DEAD, 1'b0, 1'b0},
      '{1'b1, 32'h011, 32'h00000055, 3'b000, 32'h0,        1'b0, 1'b1},
      '{1'b0, 32'h010, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 1'b0},
      '{1'b0, 32'h010, 32'h0,        3'b000, 32'hFFFFFFEF, 1'b0, 1'b0},
      '{1'b0, 32'h010, 32'h0,        3'b001, 32'h000055EF, 1'b0, 1'b0},
      '{1'b0, 32'h012, 32'h0,        3'b010, 32'h0,        1'b1, 1'b0},
      '{1'b1, 32'h011, 32'h0000BBBB, 3'b001, 32'h0,        1'b1, 1'b0},
      '{1'b0, 32'h010, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 1'b0},
      '{1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1, 1'b0},
      '{1'b1, 32'h014, 32'h11223344, 3'b010, 32'h0,        1'b0, 1'b0},
      '{1'b1, 32'h016, 32'h0000ABCD, 3'b001, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h014, 32'h0,        3'b010, 32'hABCD3344, 1'b0, 1'b0},
      '{1'b0, 32'h015, 32'h0,        3'b100, 32'h00000033, 1'b0, 1'b0},
      '{1'b0, 32'h010, 32'h0,        3'b011, 32'h0,        1'b1, 1'b0},
      '{1'b1, 32'h010, 32'h000000FF, 3'b100, 32'h0,        1'b1, 1'b0},
      '{1'b0, 32'h010, 32'h0,        3'b110, 32'h0,        1'b1, 1'b0},
      '{1'b1, 32'h3FC, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h3FE, 32'h0,        3'b001, 32'hFFFFCAFE, 1'b0, 1'b0},
      '{1'b1, 32'h020, 32'h00000000, 3'b010, 32'h0,        1'b0, 1'b0}
    };

    rst_n = 1'b0; rst1_n = 1'b0;
    clear_req();
    mem_read = 1'b1;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0; f31 = '0;

    // Reset held two cycles with a read request asserted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
    end
    clear_req();
    rst_n = 1'b1; rst1_n = 1'b1;

    for (int i = 0; i < NVEC; i++) issue(tbl[i]);

    // Reset during WAIT abandons the store: no response, no write.
    @(negedge clk); #1;
    mem_write = 1'b1; address = 32'h20; write_data = 32'h1; funct3 = 3'b010;
    @(negedge clk); #1;
    clear_req();
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy_cleared", {31'd0, busy}, 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    last_rd = 32'h0;
    repeat (4) @(negedge clk);
    issue('{1'b0, 32'h020, 32'h0, 3'b010, 32'h0, 1'b0, 1'b0});

    // LATENCY=1 instance: response one cycle after acceptance.
    l1_req(1'b1, 32'h020, 32'h0,        3'b010, 32'h0,        1'b0, 1'b0);
    l1_req(1'b1, 32'h024, 32'h8000A5A5, 3'b010, 32'h0,        1'b0, 1'b0);
    l1_req(1'b0, 32'h024, 32'h0,        3'b010, 32'h8000A5A5, 1'b0, 1'b0);
    l1_req(1'b1, 32'h020, 32'h1,        3'b010, 32'h0,        1'b0, 1'b1);
    l1_req(1'b0, 32'h020, 32'h0,        3'b010, 32'h0,        1'b0, 1'b0);
    l1_req(1'b0, 32'h026, 32'h0,        3'b001, 32'hFFFF8000, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
